// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the bit-serial SHA-256 datapath.
// Generates the shared bit clock (bclk) and bit index (counter), and streams
// words LSB-first on 'out'. Outputs change on the bclk falling-edge event so
// downstream stages can sample them on bclk rising edges.
module bit_serializer #(
    parameter int w_word = 32,
    parameter int div    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [w_word-1:0]         in_data,
    output logic                      in_ready,
    output logic                      bclk,
    output logic [$clog2(w_word)-1:0] counter,
    output logic                      out,
    output logic                      word_start,
    output logic                      busy
);

    localparam int CW = $clog2(w_word);
    localparam int PW = (div > 2) ? $clog2(div) : 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(div - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(div / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(w_word - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [PW-1:0]       ph;
    logic [PW-1:0]       ph_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                fall_evt;
    logic                boundary;
    logic                transfer;
    logic                held_valid;
    logic [w_word-1:0]   held_data;
    logic [w_word-1:0]   shreg;

    // Phase bookkeeping: falling-edge event, word boundary and handshake decode
    always_comb begin
        ph_nxt   = (ph == PH_LAST) ? '0 : ph + 1'b1;
        cnt_nxt  = counter + 1'b1;
        fall_evt = (ph == PH_LAST);
        boundary = fall_evt && (counter == CNT_LAST);
        transfer = in_valid && in_ready;
    end

    // The holding register is the only source of back-pressure
    assign in_ready = ~held_valid;

    // Phase counter and registered bit clock (high for the upper half of the phase range)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph   <= '0;
            bclk <= 1'b0;
        end else begin
            ph   <= ph_nxt;
            bclk <= (ph_nxt >= PH_HALF);
        end
    end

    // Free-running bit index; reset value makes the first falling event land on bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= CNT_LAST;
        end else if (fall_evt) begin
            counter <= cnt_nxt;
        end
    end

    // Holding-register occupancy; a boundary consumes the word held before that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid <= 1'b0;
        end else if (boundary && held_valid) begin
            held_valid <= 1'b0;
        end else if (transfer) begin
            held_valid <= 1'b1;
        end
    end

    // Holding-register data; only meaningful while held_valid is set
    always_ff @(posedge clk) begin
        if (transfer) begin
            held_data <= in_data;
        end
    end

    // Word in flight; indexed by the bit counter rather than shifted
    always_ff @(posedge clk) begin
        if (boundary && held_valid) begin
            shreg <= held_data;
        end
    end

    // Serializer FSM: decides at each boundary whether a word streams, then walks its bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out        <= 1'b0;
            word_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_start <= 1'b0;
            if (boundary) begin
                if (held_valid) begin
                    state      <= SHIFT;
                    out        <= held_data[0];
                    word_start <= 1'b1;
                    busy       <= 1'b1;
                end else begin
                    state <= IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            end else if (fall_evt && (state == SHIFT)) begin
                out <= shreg[cnt_nxt];
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer (w_word=32, div=4): scoreboard of accepted words,
// compared against the serial stream reassembled from 'out'.
module tb_bit_serializer;

    localparam int W   = 32;
    localparam int DIV = 4;
    localparam int CW  = $clog2(W);
    localparam time CLK_P = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          bclk;
    logic [CW-1:0] counter;
    logic          out;
    logic          word_start;
    logic          busy;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  exp_q[$];
    bit            flood_stop;

    bit_serializer #(.w_word(W), .div(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bclk      (bclk),
        .counter   (counter),
        .out       (out),
        .word_start(word_start),
        .busy      (busy)
    );

    always #(CLK_P / 2) clk = ~clk;

    // Drive one word through the handshake; push it to the scoreboard on the transfer edge
    task automatic send_word(input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 400; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                exp_q.push_back(d);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Wait for word_start, then reassemble 32 bits; bad counts malformed samples
    task automatic collect(output logic [W-1:0] w, output time t_start, output bit got,
                           output int bad, output logic rdy);
        got = 1'b0; bad = 0; w = '0; t_start = 0; rdy = 1'bx;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (word_start === 1'b1) got = 1'b1;
        end
        if (!got) return;
        t_start = $time;
        rdy = in_ready;
        for (int k = 0; k < W; k++) begin
            if (k > 0) @(negedge clk);
            w[k] = out;
            if (busy !== 1'b1 || counter !== CW'(k)) bad++;
            if (k > 0 && word_start !== 1'b0) bad++;
            for (int c = 1; c < DIV; c++) begin
                @(negedge clk);
                if (out !== w[k] || word_start !== 1'b0 || busy !== 1'b1) bad++;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0]    bclk_pat;
        logic [CW-1:0] ek;
        int            bad;
        bclk_pat = 4'b0110;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (counter !== CW'(W - 1)) begin errors++; $display("FAIL rst_counter: got %0d want %0d", counter, W - 1); end
        checks++; if ({bclk, out, word_start, busy} !== 4'b0000) begin errors++; $display("FAIL rst_outputs: got %b want 0000", {bclk, out, word_start, busy}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        for (int j = 0; j < DIV; j++) begin
            @(negedge clk);
            checks++; if (bclk !== bclk_pat[j]) begin errors++; $display("FAIL bclk_phase%0d: got %b want %b", j + 1, bclk, bclk_pat[j]); end
            ek = (j == DIV - 1) ? '0 : CW'(W - 1);
            checks++; if (counter !== ek) begin errors++; $display("FAIL first_f_counter%0d: got %0d want %0d", j + 1, counter, ek); end
        end
        bad = 0;
        for (int k = 1; k <= W; k++) begin
            repeat (DIV) @(negedge clk);
            ek = CW'(k);
            if (counter !== ek) bad++;
            if (out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || bclk !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_count_cycle: got %0d bad samples want 0", bad); end
    endtask

    task automatic test_single;
        bit ok, got; int bad; time t; logic rdy; logic [W-1:0] w, e;
        send_word(32'h0000_0001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_send: got timeout want transfer"); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b want 0", in_ready); end
        collect(w, t, got, bad, rdy);
        checks++; if (!got) begin errors++; $display("FAIL single_start: got no word_start want pulse"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w !== e) begin errors++; $display("FAIL single_word: got %h want %h", w, e); end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_stream: got %0d bad samples want 0", bad); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready_after_load: got %b want 1", rdy); end
        @(negedge clk);
        checks++; if ({busy, out, word_start, in_ready} !== 4'b0001) begin errors++; $display("FAIL single_idle_after: got %b want 0001", {busy, out, word_start, in_ready}); end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2, g1, g2; int b1, b2; time t1, t2; logic r1, r2; logic [W-1:0] w1, w2, e;
        fork
            begin
                send_word(32'h8000_0000, ok1);
                send_word(32'hA5A5_A5A5, ok2);
            end
            begin
                collect(w1, t1, g1, b1, r1);
                collect(w2, t2, g2, b2, r2);
            end
        join
        checks++; if (!(ok1 && ok2 && g1 && g2)) begin errors++; $display("FAIL b2b_handshake: got %b%b%b%b want 1111", ok1, ok2, g1, g2); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w1 !== e) begin errors++; $display("FAIL b2b_word1: got %h want %h", w1, e); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w2 !== e) begin errors++; $display("FAIL b2b_word2: got %h want %h", w2, e); end
        checks++; if (b1 + b2 != 0) begin errors++; $display("FAIL b2b_stream: got %0d bad samples want 0", b1 + b2); end
        checks++; if (t2 - t1 != 128 * CLK_P) begin errors++; $display("FAIL b2b_gap: got %0t want %0t", t2 - t1, 128 * CLK_P); end
    endtask

    task automatic test_transfer_on_boundary;
        bit found, got; int bad; time t0, t; logic rdy; logic [W-1:0] w, e;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (counter === CW'(W - 1) && bclk === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bnd_align: got timeout want counter=31"); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bnd_idle_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 32'h3C3C_0F0F;
        @(posedge clk);
        exp_q.push_back(32'h3C3C_0F0F);
        #1; in_valid = 1'b0; in_data = $urandom;
        @(negedge clk);
        t0 = $time;
        checks++; if (counter !== '0) begin errors++; $display("FAIL bnd_counter: got %0d want 0", counter); end
        checks++; if ({out, busy, word_start, in_ready} !== 4'b0000) begin errors++; $display("FAIL bnd_not_loaded: got %b want 0000", {out, busy, word_start, in_ready}); end
        collect(w, t, got, bad, rdy);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w !== e) begin errors++; $display("FAIL bnd_word: got %h want %h", w, e); end
        checks++; if (t - t0 != 128 * CLK_P) begin errors++; $display("FAIL bnd_latency: got %0t want %0t", t - t0, 128 * CLK_P); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bnd_stream: got %0d bad samples want 0", bad); end
    endtask

    task automatic test_full_backpressure;
        bit ok1, ok2, g1, g2; int b1, b2; time t1, t2; logic r1, r2; logic [W-1:0] w1, w2, e;
        flood_stop = 1'b0;
        fork
            begin
                send_word(32'hFFFF_FFFF, ok1);
                send_word(32'h1234_5678, ok2);
                @(negedge clk);
                in_valid = 1'b1;
                while (!flood_stop) begin
                    in_data = $urandom;
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready at %0t: got %b want 0", $time, in_ready); end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                collect(w1, t1, g1, b1, r1);
                flood_stop = 1'b1;
                collect(w2, t2, g2, b2, r2);
            end
        join
        checks++; if (!(ok1 && ok2 && g1 && g2)) begin errors++; $display("FAIL full_handshake: got %b%b%b%b want 1111", ok1, ok2, g1, g2); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w1 !== e) begin errors++; $display("FAIL full_word1: got %h want %h", w1, e); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (w2 !== e) begin errors++; $display("FAIL full_word2: got %h want %h", w2, e); end
        checks++; if (t2 - t1 != 128 * CLK_P || b1 + b2 != 0) begin errors++; $display("FAIL full_stream: got gap %0t bad %0d want %0t 0", t2 - t1, b1 + b2, 128 * CLK_P); end
        @(negedge clk);
        checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL full_no_extra: got %b want 01", {busy, in_ready}); end
    endtask

    task automatic test_reset_mid_word;
        bit ok1, ok2, found; int bad;
        send_word(32'hDEAD_BEEF, ok1);
        send_word(32'h0F0F_1234, ok2);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (counter === CW'(17) && busy === 1'b1) found = 1'b1;
        end
        checks++; if (!(found && ok1 && ok2)) begin errors++; $display("FAIL mid_setup: got %b%b%b want 111", found, ok1, ok2); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_held: got %b want 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (counter !== CW'(W - 1)) begin errors++; $display("FAIL mid_async_counter: got %0d want %0d", counter, W - 1); end
        checks++; if ({bclk, out, word_start, busy, in_ready} !== 5'b00001) begin errors++; $display("FAIL mid_async_outputs: got %b want 00001", {bclk, out, word_start, busy, in_ready}); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (DIV - 1) @(negedge clk);
        checks++; if (counter !== CW'(W - 1)) begin errors++; $display("FAIL mid_pre_f: got %0d want %0d", counter, W - 1); end
        @(negedge clk);
        checks++; if (counter !== '0) begin errors++; $display("FAIL mid_first_f: got %0d want 0", counter); end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || out !== 1'b0 || word_start !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_silent: got %0d bad samples want 0", bad); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flood_stop = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_transfer_on_boundary();
        test_full_backpressure();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the bit-serial SHA-256 datapath. Accepts w_word-bit words over a valid/ready handshake and generates the shared bit clock (bclk) and bit index (counter). Streams each word LSB-first on a single wire to the shift, rotate and add stages downstream. Those stages record on bclk rising edges and change their outputs on bclk falling edges; this block follows the same timing.

Parameters:
w_word, 32, word width in bits; must be a power of two, at least 4.
div, 4, clk cycles per bclk period; must be even, at least 2.

Ports:
clk  input  1  system clock; all state updates on posedge clk.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a word on in_data.
in_data  input  w_word  parallel word; bit 0 is sent first.
in_ready  output  1  block can accept a word this cycle.
bclk  output  1  free-running bit clock; downstream samples on its rising edge.
counter  output  $clog2(w_word)  index of the bit currently on out.
out  output  1  serial data bit.
word_start  output  1  one-clk pulse when bit 0 of a word first appears on out.
busy  output  1  out is carrying a valid word bit.

Behaviour:
- Phase counter ph counts 0..div-1 and wraps.
  - bclk = (ph >= div/2), registered.
  - Rising edge of bclk: the clk edge where ph goes div/2-1 -> div/2.
  - Falling-edge event F: the clk edge where ph goes div-1 -> 0.
- Reset (asynchronous, active-high) applies these values while rst is high:
  - ph=0, bclk=0, counter=w_word-1, out=0, word_start=0, busy=0.
  - Holding register empty, so in_ready=1; state IDLE.
  - Reset in mid-word abandons the word and the held word; no partial output after release.
- counter advances only on F: counter+1, wrapping w_word-1 -> 0. The first F after reset gives counter=0.
- Word boundary B: an F event on which counter wraps to 0.
- Counter, out and busy are free-running and word-aligned. A word always starts at counter=0.
- Holding register (one-deep):
  - in_ready = not held_valid (combinational from registered state).
  - A transfer is any clk edge with in_valid and in_ready high. It captures in_data and sets held_valid.
- Boundary B loads the value of held_valid from before the edge:
  - A transfer on the same edge as B is held until the next B.
  - If held_valid: move the held word into the shift register, clear held_valid, drive out=bit 0, pulse word_start for 1 clk, set busy=1, state SHIFT.
  - If not held_valid: out=0, busy=0, state IDLE.
- In SHIFT, the F with counter=k drives out=word bit k. out is stable for a full bclk period around each rising edge.
- Back-to-back throughput: a word held before B streams with no gap. busy stays 1 across the boundary and word_start pulses again.
- Latency: transfer at edge T puts bit 0 on out at the first B strictly after T.
- in_data is ignored when no transfer occurs. A word in flight is unaffected by a new transfer.
- No arithmetic on data; counter wraps modulo w_word.

Test Plan:
1. Reset release, idle, w_word=32, div=4 -> bclk period is 4 clk with high phases at ph 2,3; the first F sets counter=0; out=0, busy=0, in_ready=1; counter cycles 0..31.
2. Single word 0x0000_0001 accepted while IDLE -> in_ready drops next clk. At the next B: word_start pulses, out=1 for counter=0, out=0 for counter 1..31, busy=1 for 32 bclk periods. Then busy=0 and in_ready=1 after the load.
3. Words 0x8000_0000 and 0xA5A5_A5A5 back-to-back, the second sent as soon as in_ready rises -> no gap. out=1 only at counter=31 of word 1, then word 2 LSB-first (1,0,1,0,0,1,0,1,...). Two word_start pulses exactly 128 clk apart.
4. Transfer on exactly the B edge while IDLE -> the word is not loaded at that B, out stays 0, and it starts at the following B, 32 bclk periods later.
5. Assert in_valid with new data for the whole of word 1 (0xFFFF_FFFF), holding register already full -> in_ready=0 throughout. Word 1 is unchanged; the held word follows at the next B.
6. Assert rst at counter=17 of a word with a second word held -> all outputs return to reset values asynchronously. After release the first F gives counter=0, and nothing is streamed until a new transfer.
